// File: rtl/aes_inv_sub_bytes_if.sv
`default_nettype none
// ============================================================================
// Module   : aes_inv_sub_bytes_if
// Brief    : Input/output valid-ready handshake bundle for aes_inv_sub_bytes.
// Revision : 1.0
// ============================================================================
interface aes_inv_sub_bytes_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  // master drives the state in and accepts the result; slave is the engine
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface
`default_nettype wire

// File: rtl/aes_inv_sub_bytes.sv
`default_nettype none
// ============================================================================
// Module   : aes_inv_sub_bytes
// Brief    : Iterative AES InvSubBytes, BYTES_PER_CYCLE bytes substituted per clock.
// Revision : 1.0
// ============================================================================
module aes_inv_sub_bytes #(
  parameter int DATA_WIDTH      = 8,
  parameter int BYTES_PER_CYCLE = 1,
  parameter int NUM_BYTES       = 16
) (
  input  wire logic          clk,
  input  wire logic          rst,
  aes_inv_sub_bytes_if.slave bus,
  output logic               busy
);

  localparam int c_num_grp = NUM_BYTES / BYTES_PER_CYCLE;
  localparam int c_grp_w   = (c_num_grp > 1) ? $clog2(c_num_grp) : 1;
  localparam int c_idx_w   = $clog2(NUM_BYTES);
  localparam logic [c_grp_w-1:0] c_last_grp = c_grp_w'(c_num_grp - 1);

  generate
    if (DATA_WIDTH != 8) begin : g_chk_width
      $error("aes_inv_sub_bytes: DATA_WIDTH must be 8");
    end
    if (NUM_BYTES != 16) begin : g_chk_bytes
      $error("aes_inv_sub_bytes: NUM_BYTES must be 16");
    end
    if (BYTES_PER_CYCLE != 1 && BYTES_PER_CYCLE != 2 && BYTES_PER_CYCLE != 4 &&
        BYTES_PER_CYCLE != 8 && BYTES_PER_CYCLE != 16) begin : g_chk_bpc
      $error("aes_inv_sub_bytes: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  localparam logic [DATA_WIDTH-1:0] c_inv_sbox [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                               r_state, w_state_nxt;
  logic [c_grp_w-1:0]                   r_grp, w_grp_nxt;
  logic [NUM_BYTES-1:0][DATA_WIDTH-1:0] r_data, w_data_nxt, w_sub_data;
  logic [c_idx_w-1:0]                   w_base;
  logic [DATA_WIDTH-1:0]                w_lane_sub [BYTES_PER_CYCLE];

  assign w_base = c_idx_w'(int'(r_grp) * BYTES_PER_CYCLE);

  // Only BYTES_PER_CYCLE table lookups exist; each lane reads its byte of the current group.
  for (genvar b = 0; b < BYTES_PER_CYCLE; b++) begin : g_lane
    assign w_lane_sub[b] = c_inv_sbox[r_data[w_base + c_idx_w'(b)]];
  end

  for (genvar i = 0; i < NUM_BYTES; i++) begin : g_byte
    localparam logic [c_grp_w-1:0] c_grp = c_grp_w'(i / BYTES_PER_CYCLE);
    assign w_sub_data[i] = (r_grp == c_grp) ? w_lane_sub[i % BYTES_PER_CYCLE] : r_data[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_grp   <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grp   <= w_grp_nxt;
      r_data  <= w_data_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grp_nxt   = r_grp;
    w_data_nxt  = r_data;
    case (r_state)
      ST_IDLE: begin
        if (bus.in_valid) begin
          w_data_nxt  = bus.in_data;
          w_grp_nxt   = '0;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        w_data_nxt = w_sub_data;
        if (r_grp == c_last_grp) begin
          w_grp_nxt   = '0;
          w_state_nxt = ST_DONE;
        end else begin
          w_grp_nxt = r_grp + 1'b1;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs decode the state register alone, so reset clears them without a clock.
  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.out_data  = r_data;
  assign busy          = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_aes_inv_sub_bytes.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_inv_sub_bytes
// Brief    : Bench for aes_inv_sub_bytes at BYTES_PER_CYCLE = 1, 2, 4 and 16.
// Revision : 1.0
// ============================================================================
module tb_aes_inv_sub_bytes;

  typedef struct packed {
    logic [127:0] din;
    logic [127:0] dexp;
  } vec_t;

  logic         clk       = 1'b0;
  logic         rst       = 1'b1;
  logic         in_valid  = 1'b0;
  logic [127:0] in_data   = '0;
  logic         out_ready = 1'b1;
  logic [3:0]   en        = 4'hF;

  logic [3:0]   ir, ov, bz;
  logic [127:0] od [4];

  logic [127:0] exp_q [4][$];
  int           acc0_q[$];
  int           cyc    = 0;
  int           npass  = 0;
  int           ntotal = 0;
  vec_t         tbl [4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    ntotal++;
    $display("FAIL %s: got no response, expected one within the cycle budget", name);
  endtask

  for (genvar k = 0; k < 4; k++) begin : g_dut
    localparam int c_bpc = (k == 0) ? 1 : (k == 1) ? 2 : (k == 2) ? 4 : 16;
    aes_inv_sub_bytes_if dut_if ();

    assign dut_if.in_valid  = in_valid & en[k];
    assign dut_if.in_data   = in_data;
    assign dut_if.out_ready = out_ready;
    assign ir[k]            = dut_if.in_ready;
    assign ov[k]            = dut_if.out_valid;
    assign od[k]            = dut_if.out_data;

    aes_inv_sub_bytes #(
      .DATA_WIDTH      (8),
      .BYTES_PER_CYCLE (c_bpc),
      .NUM_BYTES       (16)
    ) u_dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (dut_if),
      .busy (bz[k])
    );

    int   acc_cyc = 0;
    logic prev_ov = 1'b0;

    // Scoreboard side: latency on each rising out_valid, result on each output handshake.
    always @(negedge clk) begin
      if (!rst) begin
        if (ov[k] && !prev_ov)
          chk($sformatf("latency_bpc%0d", c_bpc), 128'(cyc - acc_cyc), 128'(16 / c_bpc));
        if (ov[k] && out_ready) begin
          if (exp_q[k].size() == 0) fail_now($sformatf("unexpected_out_bpc%0d", c_bpc));
          else chk($sformatf("result_bpc%0d", c_bpc), od[k], exp_q[k].pop_front());
        end
        if (en[k] && in_valid && ir[k]) begin
          acc_cyc = cyc + 1;
          if (k == 0) acc0_q.push_back(cyc + 1);
        end
      end
      prev_ov = ov[k];
    end
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // Forward S-box from first principles: GF(2^8) inverse followed by the affine map.
  function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    for (int y = 1; y < 256; y++) if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic int pending();
    int s = 0;
    for (int k = 0; k < 4; k++) s += exp_q[k].size();
    return s;
  endfunction

  task automatic send(input logic [127:0] d, input logic [127:0] e);
    int n = 0;
    while (((ir & en) != en) && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) fail_now("send_wait_ready");
    in_valid = 1'b1;
    in_data  = d;
    for (int k = 0; k < 4; k++) if (en[k]) exp_q[k].push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((bz != 4'h0 || pending() != 0) && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) fail_now("wait_idle");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, n;
    logic [7:0] sx;
    tbl[0] = {128'h0, {16{8'h52}}};
    tbl[1] = {128'h00000000_00000000_000000ED_16FF7C63, 128'h52525252_52525252_52525253_FF7D0100};
    tbl[2] = {{16{8'hFF}}, {16{8'h7D}}};
    tbl[3] = {128'h0F0E0D0C_0B0A0908_07060504_03020100, 128'hFBD7F381_9EA340BF_38A53630_D56A0952};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 128'(ov), 128'h0);
    chk("rst_busy", 128'(bz), 128'h0);
    chk("rst_out_data", od[0], 128'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 128'(ir), 128'hF);
    @(posedge clk); #1;

    // in_ready must fall right after the accept edge
    in_valid = 1'b1; in_data = tbl[0].din;
    for (int k = 0; k < 4; k++) exp_q[k].push_back(tbl[0].dexp);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("in_ready_drop", 128'(ir), 128'h0);
    wait_idle();

    for (int i = 0; i < 4; i++) send(tbl[i].din, tbl[i].dexp);
    wait_idle();

    for (int x = 0; x < 256; x++) begin
      sx = fwd_sbox(8'(x));
      send({16{sx}}, {16{8'(x)}});
    end
    wait_idle();

    // Backpressure: results hold in DONE, a second request waits for IDLE
    out_ready = 1'b0;
    send(tbl[1].din, tbl[1].dexp);
    n = 0;
    while (ov != 4'hF && n < 40) begin @(posedge clk); #1; n++; end
    chk("bp_all_valid", 128'(ov), 128'hF);
    a0 = acc0_q.size();
    in_valid = 1'b1; in_data = tbl[3].din;
    for (int k = 0; k < 4; k++) exp_q[k].push_back(tbl[3].dexp);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 128'(ov), 128'hF);
      chk("bp_in_ready", 128'(ir), 128'h0);
      for (int k = 0; k < 4; k++) chk("bp_out_data", od[k], tbl[1].dexp);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle_ready", 128'(ir), 128'hF);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_single_accept", 128'(acc0_q.size() - a0), 128'd1);
    wait_idle();

    // Asynchronous reset with the BPC=1 engine at grp=7
    send(tbl[3].din, tbl[3].dexp);
    repeat (7) @(posedge clk);
    #1;
    chk("mid_busy", 128'(bz[0]), 128'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 128'(ov), 128'h0);
    chk("arst_busy", 128'(bz), 128'h0);
    chk("arst_out_data0", od[0], 128'h0);
    chk("arst_out_data1", od[1], 128'h0);
    for (int k = 0; k < 4; k++) exp_q[k].delete();
    #3;
    rst = 1'b0;
    #1;
    chk("arst_in_ready", 128'(ir), 128'hF);
    @(posedge clk); #1;
    send(tbl[2].din, tbl[2].dexp);
    wait_idle();

    // Back-to-back on the BPC=1 engine with in_valid and out_ready held high
    en = 4'b0001;
    a0 = acc0_q.size();
    in_valid = 1'b1; in_data = tbl[3].din;
    exp_q[0].push_back(tbl[3].dexp);
    @(posedge clk); #1;
    in_data = tbl[1].din;
    exp_q[0].push_back(tbl[1].dexp);
    n = 0;
    while (acc0_q.size() < a0 + 2 && n < 40) begin @(posedge clk); #1; n++; end
    in_valid = 1'b0;
    if (acc0_q.size() >= a0 + 2)
      chk("b2b_interval", 128'(acc0_q[a0 + 1] - acc0_q[a0]), 128'd18);
    else
      fail_now("b2b_second_accept");
    wait_idle();
    en = 4'hF;

    for (int k = 0; k < 4; k++) chk("drain", 128'(exp_q[k].size()), 128'd0);
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aes_inv_sub_bytes.md
Name: aes_inv_sub_bytes

Overview:
- Iterative InvSubBytes engine for the AES-128 decryption datapath; the inverse of the forward S-box substitution.
- Accepts one 128-bit state word over a valid/ready handshake.
- Substitutes BYTES_PER_CYCLE bytes per clock through an internal 256-entry inverse S-box.
- Presents the result on a valid/ready output port. It sits between InvShiftRows and AddRoundKey in the decryption round loop.

Parameters:
- DATA_WIDTH, 8, byte width of one S-box entry (fixed at 8; any other value is an elaboration error).
- BYTES_PER_CYCLE, 1, bytes substituted per clock; legal values 1, 2, 4, 8, 16; any other value is an elaboration error.
- NUM_BYTES, 16, bytes per AES state (fixed).

Ports:
- clk  input  1  single clock; all flops are rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a state.
- in_data  input  128  state in; byte i = in_data[8*i+7:8*i].
- out_valid  output  1  out_data holds a completed result.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  128  substituted state; byte i = InvSbox(in byte i).
- busy  output  1  high in BUSY and DONE.

Behaviour:
- Lookup: row = byte[7:4], col = byte[3:0]. Inverse table is the standard FIPS-197 InvSbox.
  - InvSbox(S(x)) = x for all x.
  - Anchor entries: [0][0]=0x52, [6][3]=0x00, [7][C]=0x01, [F][F]=0x7D, [1][6]=0xFF.
  - Table is constant and synthesizable (case ROM or localparam array), not initial-block loaded.
- FSM states IDLE, BUSY, DONE. Index counter grp, width log2(16/BYTES_PER_CYCLE) (minimum 1 bit).
- Reset (async, any time, including mid-BUSY or DONE):
  - state=IDLE, grp=0, data register=0.
  - in_ready=1 after release; out_valid=0, out_data=0, busy=0.
  - No partial result survives reset.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready at an edge: capture in_data into the state register, grp=0, go BUSY.
  - in_data is sampled only at this edge.
- BUSY:
  - in_ready=0.
  - Each edge, bytes grp*BPC .. grp*BPC+BPC-1 of the register are replaced in place by their InvSbox value, then grp increments.
  - On the edge that processes the last group (grp = 16/BPC-1): grp wraps to 0 and state goes to DONE.
  - in_valid is ignored while BUSY.
- DONE:
  - out_valid=1; out_data = state register, held stable until handshake.
  - On out_valid && out_ready: go IDLE, out_valid=0 next cycle.
  - in_ready stays 0 in DONE; no input is accepted in the cycle of the output handshake. The next accept occurs at the earliest one cycle later, from IDLE.
- Latency: out_valid rises 16/BPC clocks after the accept edge (BPC=1: 16; BPC=16: 1).
  - Minimum issue interval is 16/BPC + 2 cycles with out_ready held high.
- out_ready held low: DONE persists indefinitely and out_data does not change (backpressure).
- out_ready asserted before out_valid has no effect.
- out_data is driven directly from the register, so it may change while out_valid=0. Consumers must qualify it with out_valid.

Test Plan:
- Reset, then in_data=128'h0 with in_valid pulse, BPC=1 -> in_ready drops next cycle; out_valid exactly 16 cycles after accept; out_data=128'h5252...52 (all bytes 0x52).
- in_data bytes 0..15 = {0x63,0x7C,0xFF,0x16,0xED, then 0x00 x11} -> out bytes = {0x00,0x01,0x7D,0xFF,0x53, then 0x52 x11}. Repeat for BPC=2,4,16 with latencies 8, 4, 1.
- Exhaustive sweep: for x=0..255, feed the forward S-box output S(x) replicated in all 16 bytes -> every out byte equals x (round-trip against the forward table).
- Backpressure: hold out_ready=0 for 20 cycles in DONE -> out_valid stays 1, out_data constant, in_ready=0. A second in_valid asserted during this time is not accepted until IDLE.
- Async reset asserted at grp=7 mid-BUSY (no clock edge) -> outputs clear immediately: out_valid=0, busy=0. After release in_ready=1, and a fresh state processes correctly.
- Back-to-back: in_valid and out_ready held high with two distinct states -> second accept occurs 18 cycles after the first for BPC=1, and both results are correct.
